// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: register bus and CP0 interrupt handshake between CPU side and irq_ctrl
interface irq_ctrl_if #(parameter int ID_W = 3);
  logic            reg_we;
  logic [1:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            ir_out;
  logic            ir_ack;
  logic            eret;
  logic [ID_W-1:0] irq_id;
  logic            busy;
  modport master (
    output reg_we, reg_addr, reg_wdata, ir_ack, eret,
    input  reg_rdata, ir_out, irq_id, busy
  );
  modport slave (
    input  reg_we, reg_addr, reg_wdata, ir_ack, eret,
    output reg_rdata, ir_out, irq_id, busy
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller raising one request at a time to CP0
module irq_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_src,
  irq_ctrl_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state, state_d;
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
  logic [N_IRQ-1:0] s, hist, pend, pend_d, mask, edge_mode, eff, w1c, ack_clr, wdata;
  logic [ID_W-1:0] id_q, id_d, sel;
  logic wr_pend, wr_mask, wr_edge, take;
  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata;
  assign wdata   = bus.reg_wdata[N_IRQ-1:0];
  assign s       = sync_q[SYNC_STAGES-1];
  assign wr_pend = bus.reg_we && bus.reg_addr == 2'd0;
  assign wr_mask = bus.reg_we && bus.reg_addr == 2'd1;
  assign wr_edge = bus.reg_we && bus.reg_addr == 2'd2;
  assign eff     = pend & mask;
  assign take    = state == REQ && bus.ir_ack;
  assign w1c     = wr_pend ? wdata : '0;
  assign ack_clr = take ? N_IRQ'(1) << id_q : '0;
  // edge bits: W1C/ack clears lose to a fresh rising edge; level bits mirror the line
  assign pend_d  = (edge_mode & ((pend & ~w1c & ~ack_clr) | (s & ~hist))) | (~edge_mode & s);
  assign bus.ir_out = state == REQ;
  assign bus.busy   = state == SERVICE;
  assign bus.irq_id = id_q;
  assign bus.reg_rdata = bus.reg_addr == 2'd0 ? 32'(pend) :
                         bus.reg_addr == 2'd1 ? 32'(mask) :
                         bus.reg_addr == 2'd2 ? 32'(edge_mode) :
                         {bus.busy, {(31-ID_W){1'b0}}, id_q};
  // lowest-numbered active line wins
  always_comb begin
    sel = '0;
    for (int i = N_IRQ-1; i >= 0; i--) if (eff[i]) sel = ID_W'(i);
  end
  // next state; the latched ID only changes when leaving IDLE
  always_comb begin
    state_d = state;
    id_d    = id_q;
    if (state == IDLE) begin
      state_d = eff != '0 ? REQ : IDLE;
      id_d    = eff != '0 ? sel : id_q;
    end else if (state == REQ)
      state_d = bus.ir_ack ? SERVICE : (eff[id_q] ? REQ : IDLE);
    else if (state == SERVICE)
      state_d = bus.eret ? IDLE : SERVICE;
    else
      state_d = IDLE;
  end
  // state register and latched source ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      id_q  <= '0;
    end else begin
      state <= state_d;
      id_q  <= id_d;
    end
  end
  // input synchronisers, edge history and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist      <= '0;
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], irq_src};
      hist      <= s;
      pend      <= pend_d;
      mask      <= wr_mask ? wdata : mask;
      edge_mode <= wr_edge ? wdata : edge_mode;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus random traffic checked against a behavioural model
module tb_irq_ctrl;
  localparam int N = 8, SS = 2, IW = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] irq_src = '0;
  int n_cmp = 0, n_err = 0;
  irq_ctrl_if #(.ID_W(IW)) bus();
  irq_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .bus(bus.slave)
  );
  always #5 clk = ~clk;

  // model state: the line seen by the controller is irq_src delayed SS samples
  logic [N-1:0] sq[$];
  logic [N-1:0] m_s, m_prev, m_pend, m_mask, m_edge, np, eff;
  logic m_req, m_svc;
  logic [IW-1:0] m_id;
  int sel;
  logic [31:0] d;

  task automatic model_reset();
    sq = {};
    repeat (SS) sq.push_back('0);
    m_s = '0; m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '1;
    m_req = 1'b0; m_svc = 1'b0; m_id = '0;
  endtask

  task automatic model_step();
    eff = m_pend & m_mask;
    sel = -1;
    for (int i = N-1; i >= 0; i--) if (eff[i]) sel = i;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        np[i] = m_pend[i];
        if (bus.reg_we && bus.reg_addr == 2'd0 && bus.reg_wdata[i]) np[i] = 1'b0;
        if (m_req && bus.ir_ack && int'(m_id) == i) np[i] = 1'b0;
        if (m_s[i] && !m_prev[i]) np[i] = 1'b1;
      end else np[i] = m_s[i];
    end
    if (m_svc) m_svc = !bus.eret;
    else if (m_req) begin
      if (bus.ir_ack) begin m_req = 1'b0; m_svc = 1'b1; end
      else if (!eff[m_id]) m_req = 1'b0;
    end else if (sel >= 0) begin m_req = 1'b1; m_id = IW'(sel); end
    if (bus.reg_we && bus.reg_addr == 2'd1) m_mask = bus.reg_wdata[N-1:0];
    if (bus.reg_we && bus.reg_addr == 2'd2) m_edge = bus.reg_wdata[N-1:0];
    m_pend = np;
    m_prev = m_s;
    sq.push_back(irq_src);
    void'(sq.pop_front());
    m_s = sq[0];
  endtask

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    return a == 2'd0 ? 32'(m_pend) : a == 2'd1 ? 32'(m_mask) : a == 2'd2 ? 32'(m_edge) :
           {m_svc, 28'b0, m_id};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = v;
    tick();
    bus.reg_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    bus.reg_addr = a;
    #1 v = bus.reg_rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_src = '0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    bus.ir_ack = 1'b0; bus.eret = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_req(input string nm);
    for (int k = 0; k < 20 && !bus.ir_out; k++) tick();
    n_cmp++;
    if (bus.ir_out !== 1'b1) begin n_err++; $display("FAIL %s_timeout ir_out=%b required 1", nm, bus.ir_out); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.ir_out !== 1'b0) begin n_err++; $display("FAIL rst_ir_out got %b exp 0", bus.ir_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.irq_id !== 3'd0) begin n_err++; $display("FAIL rst_id got %0d exp 0", bus.irq_id); end
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      n_cmp++; if (d !== (a == 2 ? 32'hFF : 32'h0)) begin n_err++; $display("FAIL rst_reg%0d got %h exp %h", a, d, (a == 2 ? 32'hFF : 32'h0)); end
    end
  endtask

  task automatic test_basic_edge();
    wr(2'd1, 32'h01);
    irq_src[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) irq_src[0] = 1'b0;
      n_cmp++; if (bus.ir_out !== (k >= 4)) begin n_err++; $display("FAIL basic_lat_e%0d got %b exp %b", k, bus.ir_out, k >= 4); end
      n_cmp++; if (bus.ir_out !== m_req) begin n_err++; $display("FAIL basic_model_e%0d got %b exp %b", k, bus.ir_out, m_req); end
    end
    n_cmp++; if (bus.irq_id !== 3'd0) begin n_err++; $display("FAIL basic_id got %0d exp 0", bus.irq_id); end
    bus.ir_ack = 1'b1; tick(); bus.ir_ack = 1'b0;
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL basic_pend got %h exp 0", d); end
    n_cmp++; if ({bus.busy, bus.ir_out} !== 2'b10) begin n_err++; $display("FAIL basic_svc busy,ir got %b exp 10", {bus.busy, bus.ir_out}); end
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    repeat (3) begin
      n_cmp++; if ({bus.busy, bus.ir_out} !== 2'b00) begin n_err++; $display("FAIL basic_eret busy,ir got %b exp 00", {bus.busy, bus.ir_out}); end
      tick();
    end
  endtask

  task automatic test_priority();
    wr(2'd1, 32'hFF);
    irq_src = 8'h24;
    wait_req("prio");
    irq_src = '0;
    n_cmp++; if (bus.irq_id !== 3'd2) begin n_err++; $display("FAIL prio_id got %0d exp 2", bus.irq_id); end
    bus.ir_ack = 1'b1; tick(); bus.ir_ack = 1'b0;
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h20) begin n_err++; $display("FAIL prio_pend got %h exp 20", d); end
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    n_cmp++; if (bus.ir_out !== 1'b0) begin n_err++; $display("FAIL prio_idle_gap got %b exp 0", bus.ir_out); end
    tick();
    n_cmp++; if ({bus.ir_out, bus.irq_id} !== {1'b1, 3'd5}) begin n_err++; $display("FAIL prio_second ir,id got %b/%0d exp 1/5", bus.ir_out, bus.irq_id); end
    bus.ir_ack = 1'b1; tick(); bus.ir_ack = 1'b0;
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    tick();
  endtask

  task automatic test_level();
    wr(2'd2, 32'hFE);
    wr(2'd1, 32'h01);
    irq_src[0] = 1'b1;
    wait_req("level");
    bus.ir_ack = 1'b1; tick(); bus.ir_ack = 1'b0;
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    n_cmp++; if (bus.ir_out !== 1'b0) begin n_err++; $display("FAIL level_gap got %b exp 0", bus.ir_out); end
    tick();
    n_cmp++; if (bus.ir_out !== 1'b1 || bus.ir_out !== m_req) begin n_err++; $display("FAIL level_reassert got %b exp 1", bus.ir_out); end
    bus.ir_ack = 1'b1; tick(); bus.ir_ack = 1'b0;
    irq_src[0] = 1'b0;
    repeat (SS + 1) tick();
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL level_pend_drop got %h exp 0", d); end
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    repeat (3) begin
      tick();
      n_cmp++; if (bus.ir_out !== 1'b0) begin n_err++; $display("FAIL level_noreq got %b exp 0", bus.ir_out); end
    end
    wr(2'd2, 32'hFF);
  endtask

  task automatic test_w1c_mask();
    wr(2'd1, 32'h08);
    irq_src[3] = 1'b1;
    wait_req("w1c");
    irq_src[3] = 1'b0;
    n_cmp++; if (bus.irq_id !== 3'd3) begin n_err++; $display("FAIL w1c_id got %0d exp 3", bus.irq_id); end
    wr(2'd1, 32'h00);
    tick();
    n_cmp++; if ({bus.ir_out, bus.busy} !== 2'b00) begin n_err++; $display("FAIL w1c_withdraw ir,busy got %b exp 00", {bus.ir_out, bus.busy}); end
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h08) begin n_err++; $display("FAIL w1c_pend_kept got %h exp 08", d); end
    repeat (3) tick();
    irq_src[3] = 1'b1;
    tick(); tick();
    wr(2'd0, 32'h08);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h08 || d !== m_rd(2'd0)) begin n_err++; $display("FAIL w1c_edge_wins got %h exp 08", d); end
    irq_src[3] = 1'b0;
    wr(2'd0, 32'h08);
    rd(2'd0, d);
    n_cmp++; if (d !== 32'h00) begin n_err++; $display("FAIL w1c_clear got %h exp 00", d); end
  endtask

  task automatic test_ack_eret();
    wr(2'd1, 32'h02);
    irq_src[1] = 1'b1;
    wait_req("ackeret");
    irq_src[1] = 1'b0;
    bus.ir_ack = 1'b1; bus.eret = 1'b1; tick(); bus.ir_ack = 1'b0; bus.eret = 1'b0;
    repeat (2) begin
      n_cmp++; if ({bus.busy, bus.ir_out} !== 2'b10) begin n_err++; $display("FAIL ackeret_svc busy,ir got %b exp 10", {bus.busy, bus.ir_out}); end
      tick();
    end
    bus.eret = 1'b1; tick(); bus.eret = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ackeret_idle busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ (N'($urandom) & N'($urandom));
      bus.reg_we    = $urandom_range(0, 7) == 0;
      bus.reg_addr  = 2'($urandom);
      bus.reg_wdata = $urandom;
      bus.ir_ack    = (bus.ir_out && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0;
      bus.eret      = (bus.busy && $urandom_range(0, 3) == 0) || $urandom_range(0, 15) == 0;
      tick();
      n_cmp++; if (bus.ir_out !== m_req) begin n_err++; $display("FAIL rnd_ir c%0d got %b exp %b", c, bus.ir_out, m_req); end
      n_cmp++; if (bus.busy !== m_svc) begin n_err++; $display("FAIL rnd_busy c%0d got %b exp %b", c, bus.busy, m_svc); end
      n_cmp++; if (bus.irq_id !== m_id) begin n_err++; $display("FAIL rnd_id c%0d got %0d exp %0d", c, bus.irq_id, m_id); end
      n_cmp++; if (bus.reg_rdata !== m_rd(bus.reg_addr)) begin n_err++; $display("FAIL rnd_reg%0d c%0d got %h exp %h", bus.reg_addr, c, bus.reg_rdata, m_rd(bus.reg_addr)); end
    end
    bus.reg_we = 1'b0; bus.ir_ack = 1'b0; bus.eret = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    wr(2'd1, 32'h40);
    irq_src[6] = 1'b1;
    wait_req("areset");
    irq_src[6] = 1'b0;
    bus.ir_ack = 1'b1; tick(); bus.ir_ack = 1'b0;
    n_cmp++; if ({bus.busy, bus.irq_id} !== {1'b1, 3'd6}) begin n_err++; $display("FAIL areset_pre busy,id got %b/%0d exp 1/6", bus.busy, bus.irq_id); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if ({bus.busy, bus.ir_out, bus.irq_id} !== 5'b0) begin n_err++; $display("FAIL areset_out busy,ir,id got %b exp 00000", {bus.busy, bus.ir_out, bus.irq_id}); end
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), d);
      n_cmp++; if (d !== (a == 2 ? 32'hFF : 32'h0)) begin n_err++; $display("FAIL areset_reg%0d got %h exp %h", a, d, (a == 2 ? 32'hFF : 32'h0)); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({bus.busy, bus.ir_out} !== 2'b00) begin n_err++; $display("FAIL areset_after busy,ir got %b exp 00", {bus.busy, bus.ir_out}); end
  endtask

  initial begin
    bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0; bus.ir_ack = 1'b0; bus.eret = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic_edge();
    test_priority();
    test_level();
    test_w1c_mask();
    test_ack_eret();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
